// File: rtl/motor_move_sequencer.sv
// rtl/motor_move_sequencer.sv - one MOTOR_CONTROL channel positioning move sequencer
//
// Runs one move: power-up, enable, duty ramp, run, counted stop, brake.
// Optional build macro: MOVE_SEQ_DECEL_EN adds a DECEL state that ramps the
// duty down over the last DECEL_PULSES tacho pulses of a move.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   CMD_VALID / CMD_READY    move command handshake (ready only in IDLE)
//   CMD_DIR/PULSES/DUTY      direction, target tacho edge count, target duty
//   ABORT                    level, controlled stop through BRAKE
//   FAULT_CLR                pulse, leave FAULT
//   TACHO, DIAG              asynchronous feedback (DIAG active-low)
//   M_C                      [0]=PWR [1]=EN [2]=FWDREV [3]=BR
//   DUTY_VALUE               duty to MOTOR_CONTROL
//   PULSE_CNT                tacho edges counted in current/last move
//   BUSY, DONE, FAULT_CODE   status (00 none, 01 stall, 10 diag, 11 aborted)
module motor_move_sequencer #(
    parameter logic [15:0] RAMP_STEP     = 16'd250,
    parameter int unsigned RAMP_DIV      = 50000,
    parameter int unsigned PWR_SETTLE    = 50000,
    parameter int unsigned BRAKE_HOLD    = 2500000,
    parameter int unsigned STALL_TIMEOUT = 5000000
`ifdef MOVE_SEQ_DECEL_EN
    ,
    parameter logic [15:0] DECEL_PULSES  = 16'd32
`endif
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_DIR,
    input  logic [15:0] CMD_PULSES,
    input  logic [15:0] CMD_DUTY,
    input  logic        ABORT,
    input  logic        FAULT_CLR,
    input  logic        TACHO,
    input  logic        DIAG,
    output logic [3:0]  M_C,
    output logic [15:0] DUTY_VALUE,
    output logic [15:0] PULSE_CNT,
    output logic        BUSY,
    output logic        DONE,
    output logic [1:0]  FAULT_CODE
);

    localparam logic [31:0] RAMP_LAST  = 32'(RAMP_DIV - 1);
    localparam logic [31:0] PWR_LAST   = 32'(PWR_SETTLE - 1);
    localparam logic [31:0] BRAKE_LAST = 32'(BRAKE_HOLD - 1);
    localparam logic [31:0] STALL_LAST = 32'(STALL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PWR_ON,
        ST_RAMP,
        ST_RUN,
        ST_BRAKE,
        ST_FAULT,
        ST_DECEL
    } state_t;

    state_t      state;
    logic [31:0] timer;
    logic [31:0] stall_cnt;
    logic        dir_l;
    logic [15:0] tgt_pulses;
    logic [15:0] tgt_duty;

    logic        tacho_s1, tacho_s2, tacho_s3;
    logic        diag_s1, diag_s2, diag_low_d;

    logic        tacho_edge;
    logic        diag_fault;
    logic [15:0] cnt_next;
    logic        target_hit;
    logic        stall_hit;
    logic        ramp_tick;
    logic [16:0] duty_sum;
    logic [15:0] duty_up;
`ifdef MOVE_SEQ_DECEL_EN
    logic [15:0] remaining;
    logic        decel_hit;
    logic [15:0] duty_down;
`endif

    // RST gates ready so the handshake reads 0 while reset is held
    assign CMD_READY = (state == ST_IDLE) && !RST;
    assign BUSY      = (state != ST_IDLE);

    always_comb begin
        tacho_edge = tacho_s2 & ~tacho_s3;
        // two consecutive synchronised low samples
        diag_fault = ~diag_s2 & diag_low_d;
        cnt_next   = (tacho_edge && PULSE_CNT != 16'hFFFF) ? PULSE_CNT + 16'd1 : PULSE_CNT;
        target_hit = (cnt_next >= tgt_pulses);
        // an edge on the timeout cycle itself still rescues the move
        stall_hit  = !tacho_edge && (stall_cnt == STALL_LAST);
        ramp_tick  = (timer == RAMP_LAST);
        // 17-bit sum so a large step near 16'hFFFF saturates instead of wrapping
        duty_sum   = {1'b0, DUTY_VALUE} + {1'b0, RAMP_STEP};
        duty_up    = (duty_sum >= {1'b0, tgt_duty}) ? tgt_duty : duty_sum[15:0];
`ifdef MOVE_SEQ_DECEL_EN
        remaining  = tgt_pulses - cnt_next;
        decel_hit  = (tgt_pulses > DECEL_PULSES) && (remaining <= DECEL_PULSES);
        if ({1'b0, DUTY_VALUE} >= {RAMP_STEP, 1'b0})
            duty_down = DUTY_VALUE - RAMP_STEP;
        else if (DUTY_VALUE < RAMP_STEP)
            duty_down = DUTY_VALUE;
        else
            duty_down = RAMP_STEP;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            M_C        <= 4'b0000;
            DUTY_VALUE <= 16'd0;
            PULSE_CNT  <= 16'd0;
            DONE       <= 1'b0;
            FAULT_CODE <= 2'b00;
            timer      <= 32'd0;
            stall_cnt  <= 32'd0;
            dir_l      <= 1'b0;
            tgt_pulses <= 16'd0;
            tgt_duty   <= 16'd0;
            tacho_s1   <= 1'b0;
            tacho_s2   <= 1'b0;
            tacho_s3   <= 1'b0;
            diag_s1    <= 1'b1;
            diag_s2    <= 1'b1;
            diag_low_d <= 1'b0;
        end else begin
            tacho_s1   <= TACHO;
            tacho_s2   <= tacho_s1;
            tacho_s3   <= tacho_s2;
            diag_s1    <= DIAG;
            diag_s2    <= diag_s1;
            diag_low_d <= ~diag_s2;
            DONE       <= 1'b0;

            case (state)
                ST_IDLE: begin
                    M_C        <= 4'b0000;
                    DUTY_VALUE <= 16'd0;
                    if (CMD_VALID) begin
                        dir_l      <= CMD_DIR;
                        tgt_pulses <= CMD_PULSES;
                        tgt_duty   <= CMD_DUTY;
                        PULSE_CNT  <= 16'd0;
                        FAULT_CODE <= 2'b00;
                        if (CMD_PULSES == 16'd0) begin
                            DONE <= 1'b1;
                        end else begin
                            state <= ST_PWR_ON;
                            M_C   <= {1'b0, CMD_DIR, 1'b0, 1'b1};
                            timer <= 32'd0;
                        end
                    end
                end

                ST_PWR_ON: begin
                    if (diag_fault) begin
                        state      <= ST_FAULT;
                        M_C        <= 4'b0000;
                        DUTY_VALUE <= 16'd0;
                        FAULT_CODE <= 2'b10;
                    end else if (ABORT) begin
                        state      <= ST_BRAKE;
                        M_C        <= {1'b1, dir_l, 1'b0, 1'b1};
                        DUTY_VALUE <= 16'd0;
                        FAULT_CODE <= 2'b11;
                        timer      <= 32'd0;
                    end else if (timer == PWR_LAST) begin
                        state     <= ST_RAMP;
                        M_C       <= {1'b0, dir_l, 1'b1, 1'b1};
                        timer     <= 32'd0;
                        stall_cnt <= 32'd0;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end

                // The stall window opens on RAMP entry and runs continuously
                // through RUN/DECEL; only tacho edges restart it.
                ST_RAMP, ST_RUN, ST_DECEL: begin
                    PULSE_CNT <= cnt_next;
                    stall_cnt <= tacho_edge ? 32'd0 : stall_cnt + 32'd1;
                    if (diag_fault) begin
                        state      <= ST_FAULT;
                        M_C        <= 4'b0000;
                        DUTY_VALUE <= 16'd0;
                        FAULT_CODE <= 2'b10;
                    end else if (stall_hit) begin
                        state      <= ST_FAULT;
                        M_C        <= 4'b0000;
                        DUTY_VALUE <= 16'd0;
                        FAULT_CODE <= 2'b01;
                    end else if (ABORT) begin
                        state      <= ST_BRAKE;
                        M_C        <= {1'b1, dir_l, 1'b0, 1'b1};
                        DUTY_VALUE <= 16'd0;
                        FAULT_CODE <= 2'b11;
                        timer      <= 32'd0;
                    end else if (target_hit) begin
                        state      <= ST_BRAKE;
                        M_C        <= {1'b1, dir_l, 1'b0, 1'b1};
                        DUTY_VALUE <= 16'd0;
                        timer      <= 32'd0;
`ifdef MOVE_SEQ_DECEL_EN
                    end else if (state != ST_DECEL && decel_hit) begin
                        state <= ST_DECEL;
                        timer <= 32'd0;
                    end else if (state == ST_DECEL) begin
                        if (ramp_tick) begin
                            timer      <= 32'd0;
                            DUTY_VALUE <= duty_down;
                        end else begin
                            timer <= timer + 32'd1;
                        end
`endif
                    end else if (state == ST_RAMP) begin
                        if (ramp_tick) begin
                            timer      <= 32'd0;
                            DUTY_VALUE <= duty_up;
                            if (duty_up == tgt_duty)
                                state <= ST_RUN;
                        end else begin
                            timer <= timer + 32'd1;
                        end
                    end
                end

                ST_BRAKE: begin
                    // overshoot edges remain visible in PULSE_CNT
                    PULSE_CNT <= cnt_next;
                    if (diag_fault) begin
                        state      <= ST_FAULT;
                        M_C        <= 4'b0000;
                        DUTY_VALUE <= 16'd0;
                        FAULT_CODE <= 2'b10;
                    end else if (timer == BRAKE_LAST) begin
                        state <= ST_IDLE;
                        M_C   <= 4'b0000;
                        DONE  <= 1'b1;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end

                ST_FAULT: begin
                    M_C        <= 4'b0000;
                    DUTY_VALUE <= 16'd0;
                    if (FAULT_CLR)
                        state <= ST_IDLE;
                end

                default: begin
                    state      <= ST_IDLE;
                    M_C        <= 4'b0000;
                    DUTY_VALUE <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motor_move_sequencer.sv
// tb/tb_motor_move_sequencer.sv - self-checking bench for motor_move_sequencer
module tb_motor_move_sequencer;

    localparam int RD = 4;
    localparam int PS = 8;
    localparam int BH = 16;
    localparam int ST = 200;
    localparam int STEP = 250;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic        CMD_DIR = 1'b0;
    logic [15:0] CMD_PULSES = 16'd0;
    logic [15:0] CMD_DUTY = 16'd0;
    logic        ABORT = 1'b0;
    logic        FAULT_CLR = 1'b0;
    logic        TACHO = 1'b0;
    logic        DIAG = 1'b1;
    logic [3:0]  M_C;
    logic [15:0] DUTY_VALUE;
    logic [15:0] PULSE_CNT;
    logic        BUSY;
    logic        DONE;
    logic [1:0]  FAULT_CODE;

    always #5 clk = ~clk;

    motor_move_sequencer #(
        .RAMP_STEP    (16'd250),
        .RAMP_DIV     (RD),
        .PWR_SETTLE   (PS),
        .BRAKE_HOLD   (BH),
        .STALL_TIMEOUT(ST)
`ifdef MOVE_SEQ_DECEL_EN
        ,
        .DECEL_PULSES (16'd4)
`endif
    ) dut (
        .CLK        (clk),
        .RST        (RST),
        .CMD_VALID  (CMD_VALID),
        .CMD_READY  (CMD_READY),
        .CMD_DIR    (CMD_DIR),
        .CMD_PULSES (CMD_PULSES),
        .CMD_DUTY   (CMD_DUTY),
        .ABORT      (ABORT),
        .FAULT_CLR  (FAULT_CLR),
        .TACHO      (TACHO),
        .DIAG       (DIAG),
        .M_C        (M_C),
        .DUTY_VALUE (DUTY_VALUE),
        .PULSE_CNT  (PULSE_CNT),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .FAULT_CODE (FAULT_CODE)
    );

    int total = 0;
    int bad = 0;

    // Observation of one move: distinct M_C values with their hold lengths,
    // distinct duty values, and DONE pulses.
    logic        rec = 1'b0;
    logic [3:0]  last_mc = 4'h0;
    logic [15:0] last_duty = 16'h0;
    int          run_len = 0;
    int          done_cnt = 0;
    logic [3:0]  mc_q[$];
    int          len_q[$];
    logic [15:0] duty_q[$];
    int          first_dec = -1;
    int          min_dec = 65535;

    always @(negedge clk) begin
        if (rec) begin
            if (M_C !== last_mc) begin
                mc_q.push_back(M_C);
                if (last_mc != 4'h0) len_q.push_back(run_len);
                run_len = 1;
                last_mc = M_C;
            end else begin
                run_len++;
            end
            if (DUTY_VALUE !== last_duty) begin
                if (M_C[1] && DUTY_VALUE < last_duty) begin
                    if (first_dec < 0) first_dec = int'(PULSE_CNT);
                    if (int'(DUTY_VALUE) < min_dec) min_dec = int'(DUTY_VALUE);
                end
                duty_q.push_back(DUTY_VALUE);
                last_duty = DUTY_VALUE;
            end
            if (DONE === 1'b1) done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mc_q.delete();
        len_q.delete();
        duty_q.delete();
        last_mc = 4'h0;
        last_duty = 16'h0;
        run_len = 0;
        done_cnt = 0;
        first_dec = -1;
        min_dec = 65535;
        rec = 1'b1;
    endtask

    task automatic send_cmd(input int p, input int d, input logic dir);
        @(negedge clk);
        CMD_VALID = 1'b1;
        CMD_PULSES = 16'(p);
        CMD_DUTY = 16'(d);
        CMD_DIR = dir;
        @(negedge clk);
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_en();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (M_C[1] === 1'b1) break;
        end
        check("en_reached", 32'(M_C[1]), 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 600 && done_cnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulses(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            TACHO = 1'b1;
            repeat (period / 2) @(negedge clk);
            TACHO = 1'b0;
            repeat (period - period / 2) @(negedge clk);
        end
    endtask

    // Complete move with tacho starting after the ramp has finished;
    // 'extra' pulses beyond the target are expected to land in BRAKE.
    task automatic do_move(input int p, input int d, input logic dir, input int period,
                           input int extra, input string tag);
        logic [3:0]  exp_mc[$];
        logic [15:0] exp_duty[$];
        logic [3:0]  dm;
        int          n;
        dm = {1'b0, dir, 2'b00};
        exp_mc = '{4'b0001 | dm, 4'b0011 | dm, 4'b1001 | dm, 4'b0000};
        for (int k = 1; k * STEP < d; k++) exp_duty.push_back(16'(k * STEP));
        exp_duty.push_back(16'(d));
        exp_duty.push_back(16'd0);

        clear_mon();
        send_cmd(p, d, dir);
        wait_en();
        repeat (40) @(negedge clk);
        pulses(p + extra, period);
        wait_done();

        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_pulse_cnt"}, 32'(PULSE_CNT), 32'(p + extra));
        check({tag, "_fault_code"}, 32'(FAULT_CODE), 32'd0);
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
        check({tag, "_ready"}, 32'(CMD_READY), 32'd1);
        check({tag, "_mc_steps"}, 32'(mc_q.size()), 32'(exp_mc.size()));
        n = (mc_q.size() < exp_mc.size()) ? mc_q.size() : exp_mc.size();
        for (int i = 0; i < n; i++) check({tag, "_mc"}, 32'(mc_q[i]), 32'(exp_mc[i]));
        if (len_q.size() >= 3) begin
            check({tag, "_pwr_len"}, 32'(len_q[0]), 32'(PS));
            check({tag, "_brake_len"}, 32'(len_q[2]), 32'(BH));
        end else begin
            check({tag, "_len_steps"}, 32'(len_q.size()), 32'd3);
        end
        check({tag, "_duty_steps"}, 32'(duty_q.size()), 32'(exp_duty.size()));
        n = (duty_q.size() < exp_duty.size()) ? duty_q.size() : exp_duty.size();
        for (int i = 0; i < n; i++) check({tag, "_duty"}, 32'(duty_q[i]), 32'(exp_duty[i]));
        rec = 1'b0;
    endtask

    initial begin
        int p, d, per, n;
        logic dr;

        // reset state
        repeat (3) @(negedge clk);
        RST = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(CMD_READY), 32'd1);
        check("rst_mc", 32'(M_C), 32'd0);
        check("rst_duty", 32'(DUTY_VALUE), 32'd0);
        check("rst_pulse", 32'(PULSE_CNT), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_fault", 32'(FAULT_CODE), 32'd0);

        // reference move
`ifdef MOVE_SEQ_DECEL_EN
        do_move(4, 1000, 1'b1, 20, 0, "ref");
`else
        do_move(10, 1000, 1'b1, 20, 0, "ref");
`endif

        // randomized moves
        for (int r = 0; r < 4; r++) begin
`ifdef MOVE_SEQ_DECEL_EN
            p = int'($urandom_range(4, 1));
`else
            p = int'($urandom_range(12, 1));
`endif
            d = int'($urandom_range(2000, 1));
            per = int'($urandom_range(20, 4));
            dr = 1'($urandom_range(1, 0));
            do_move(p, d, dr, per, 0, "rnd");
        end

        // overshoot counted during BRAKE
        do_move(3, 500, 1'b0, 4, 2, "over");

        // zero-pulse command
        clear_mon();
        send_cmd(0, 500, 1'b1);
        check("zero_done", 32'(DONE), 32'd1);
        check("zero_busy", 32'(BUSY), 32'd0);
        check("zero_mc", 32'(M_C), 32'd0);
        @(negedge clk);
        check("zero_done_once", 32'(DONE), 32'd0);
        repeat (4) @(negedge clk);
        check("zero_mc_quiet", 32'(mc_q.size()), 32'd0);
        check("zero_busy_after", 32'(BUSY), 32'd0);
        rec = 1'b0;

        // stall
        clear_mon();
        send_cmd(5, 500, 1'b0);
        wait_en();
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            if (FAULT_CODE != 2'b00) break;
        end
        check("stall_code", 32'(FAULT_CODE), 32'd1);
        check("stall_time_window", 32'(n >= ST - 2 && n <= ST + 1), 32'd1);
        check("stall_mc", 32'(M_C), 32'd0);
        check("stall_duty", 32'(DUTY_VALUE), 32'd0);
        check("stall_busy", 32'(BUSY), 32'd1);
        repeat (5) @(negedge clk);
        check("stall_ready_held", 32'(CMD_READY), 32'd0);
        FAULT_CLR = 1'b1;
        @(negedge clk);
        FAULT_CLR = 1'b0;
        check("stall_clr_ready", 32'(CMD_READY), 32'd1);
        check("stall_code_kept", 32'(FAULT_CODE), 32'd1);
        repeat (3) @(negedge clk);
        check("stall_no_done", 32'(done_cnt), 32'd0);
        rec = 1'b0;

        // diag: glitch ignored, sustained low faults
        clear_mon();
        send_cmd(5, 1000, 1'b1);
        wait_en();
        repeat (40) @(negedge clk);
        DIAG = 1'b0;
        @(negedge clk);
        DIAG = 1'b1;
        repeat (6) @(negedge clk);
        check("diag_glitch_code", 32'(FAULT_CODE), 32'd0);
        check("diag_glitch_mc", 32'(M_C), 32'b0111);
        check("diag_glitch_duty", 32'(DUTY_VALUE), 32'd1000);
        DIAG = 1'b0;
        repeat (3) @(negedge clk);
        DIAG = 1'b1;
        repeat (2) @(negedge clk);
        check("diag_code", 32'(FAULT_CODE), 32'd2);
        check("diag_duty", 32'(DUTY_VALUE), 32'd0);
        check("diag_mc", 32'(M_C), 32'd0);
        FAULT_CLR = 1'b1;
        @(negedge clk);
        FAULT_CLR = 1'b0;
        check("diag_clr_ready", 32'(CMD_READY), 32'd1);
        rec = 1'b0;

        // abort on the same cycle as the target edge, during RAMP
        clear_mon();
        send_cmd(1, 2000, 1'b0);
        wait_en();
        repeat (2) @(negedge clk);
        TACHO = 1'b1;
        repeat (2) @(negedge clk);
        ABORT = 1'b1;
        @(negedge clk);
        ABORT = 1'b0;
        repeat (3) @(negedge clk);
        TACHO = 1'b0;
        wait_done();
        check("abort_code", 32'(FAULT_CODE), 32'd3);
        check("abort_done", 32'(done_cnt), 32'd1);
        check("abort_pulse", 32'(PULSE_CNT), 32'd1);
        check("abort_mc_steps", 32'(mc_q.size()), 32'd4);
        if (mc_q.size() >= 4) check("abort_brake_mc", 32'(mc_q[2]), 32'b1001);
        if (len_q.size() >= 3) check("abort_brake_len", 32'(len_q[2]), 32'(BH));
        rec = 1'b0;

        // reset mid-move
        clear_mon();
        send_cmd(5, 1000, 1'b1);
        wait_en();
        repeat (40) @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        check("mid_rst_mc", 32'(M_C), 32'd0);
        check("mid_rst_duty", 32'(DUTY_VALUE), 32'd0);
        check("mid_rst_pulse", 32'(PULSE_CNT), 32'd0);
        check("mid_rst_flags", 32'({BUSY, DONE, FAULT_CODE, CMD_READY}), 32'd0);
        RST = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", 32'(CMD_READY), 32'd1);
        rec = 1'b0;

`ifdef MOVE_SEQ_DECEL_EN
        // deceleration over the last pulses
        clear_mon();
        send_cmd(10, 1000, 1'b0);
        wait_en();
        repeat (40) @(negedge clk);
        pulses(10, 20);
        wait_done();
        check("decel_start_cnt", 32'(first_dec), 32'd6);
        check("decel_floor", 32'(min_dec >= STEP), 32'd1);
        check("decel_pulse", 32'(PULSE_CNT), 32'd10);
        check("decel_done", 32'(done_cnt), 32'd1);
        rec = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/motor_move_sequencer.md
Name: motor_move_sequencer

Overview:
- Sequences one MOTOR_CONTROL channel through a complete positioning move: power-up, enable, duty ramp, run, counted stop, brake.
- Accepts a move command (direction, tacho-pulse count, duty) from the FSMC register file.
- Drives the 4-bit M_C control nibble and DUTY_VALUE of one MOTOR_CONTROL instance.
- Counts synchronised TACHO edges and reports done/fault status back into the status registers.

Parameters:
RAMP_STEP, 16'd250, duty increment applied each ramp tick
RAMP_DIV, 50000, CLK cycles per ramp tick (1 ms at 50 MHz)
PWR_SETTLE, 50000, CLK cycles between PWR on and EN on
BRAKE_HOLD, 2500000, CLK cycles BR is held before returning to IDLE
STALL_TIMEOUT, 5000000, max CLK cycles between TACHO edges while moving
DECEL_PULSES, 16'd32, pulses before target where decel starts (MOVE_SEQ_DECEL_EN only)

Ports:
CLK  input  1  system clock, 50 MHz
RST  input  1  synchronous reset, active-high
CMD_VALID  input  1  move command valid
CMD_READY  output  1  high only in IDLE; command accepted when CMD_VALID && CMD_READY
CMD_DIR  input  1  direction, copied to FWDREV
CMD_PULSES  input  16  target TACHO rising-edge count
CMD_DUTY  input  16  target duty value
ABORT  input  1  level; request controlled stop
FAULT_CLR  input  1  pulse; leave FAULT state
TACHO  input  1  asynchronous tacho feedback
DIAG  input  1  asynchronous L6235 diagnosis, active-low
M_C  output  4  [0]=PWR, [1]=EN, [2]=FWDREV, [3]=BR
DUTY_VALUE  output  16  duty to MOTOR_CONTROL
PULSE_CNT  output  16  pulses counted in the current or last move
BUSY  output  1  state != IDLE
DONE  output  1  one-cycle pulse on return to IDLE
FAULT_CODE  output  2  00 none, 01 stall, 10 diag, 11 aborted

Behaviour:
- Reset values: all outputs 0, state IDLE, CMD_READY=1 on the first cycle after RST deasserts.
- Input sync: TACHO and DIAG each pass through a 2-FF synchroniser.
  - Tacho edge = sync rising edge, 3-cycle latency from the pin.
  - Diag fault = synchronised DIAG low for 2 consecutive cycles.
- Command latch: on accept, latch DIR/PULSES/DUTY, clear PULSE_CNT, clear FAULT_CODE.
- Zero-pulse command: CMD_PULSES=0 -> DONE pulses next cycle, no output change, stays IDLE.
- IDLE: M_C=0000, DUTY_VALUE=0. Accept -> PWR_ON.
- PWR_ON: M_C[0]=1, FWDREV=DIR. After PWR_SETTLE cycles -> RAMP.
- RAMP: PWR=EN=1.
  - Every RAMP_DIV cycles, DUTY_VALUE += RAMP_STEP, saturating at the latched duty (17-bit compare, no wrap).
  - If latched duty < RAMP_STEP, the first tick loads the duty directly.
  - DUTY_VALUE == latched duty -> RUN.
- RUN: DUTY_VALUE held.
- Pulse counting (RAMP and RUN): PULSE_CNT increments per tacho edge and saturates at 16'hFFFF.
- Target reached: PULSE_CNT reaching the target (including on the edge cycle itself) -> BRAKE.
- BRAKE: EN=0, BR=1, PWR=1, DUTY_VALUE=0, FWDREV held. After BRAKE_HOLD cycles -> IDLE with DONE pulse, M_C=0000.
  - Edges arriving in BRAKE are still counted (overshoot visible), saturating.
- Stall: in RAMP/RUN, a counter is cleared on each tacho edge and on state entry. Reaching STALL_TIMEOUT -> FAULT, FAULT_CODE=01.
- Diag: a diag fault in PWR_ON/RAMP/RUN/BRAKE -> FAULT, FAULT_CODE=10. Diag is ignored in IDLE and FAULT.
- ABORT in PWR_ON/RAMP/RUN -> BRAKE, FAULT_CODE=11. The move ends with DONE as usual. ABORT in BRAKE, IDLE or FAULT has no effect.
- FAULT: M_C=0000 (power removed, no brake), DUTY_VALUE=0, CMD_READY=0, BUSY=1. FAULT_CLR -> IDLE with no DONE pulse; FAULT_CODE is retained until the next accept.
- Same-cycle priority: RST > diag/stall fault > ABORT > target reached > ramp tick.
- RST mid-move: next cycle all outputs are 0. The motor coasts unpowered; no brake is sequenced.

Optional Feature:
MOVE_SEQ_DECEL_EN
- Defined: adds a DECEL state entered from RAMP/RUN when remaining pulses (target - PULSE_CNT) <= DECEL_PULSES and the target exceeds DECEL_PULSES.
  - DUTY_VALUE -= RAMP_STEP every RAMP_DIV cycles, floor RAMP_STEP.
  - Target reached -> BRAKE. Stall, diag and ABORT rules are the same as RUN.
- Undefined: no DECEL state. Duty is held until target, then braked immediately. DECEL_PULSES is unused.

Test Plan:
1. Normal move (sim params RAMP_DIV=4, PWR_SETTLE=8, BRAKE_HOLD=16, STALL_TIMEOUT=200), CMD_PULSES=10, CMD_DUTY=1000, RAMP_STEP=250, tacho period 20 cycles:
   - M_C goes 0001 -> 0011|dir -> 1001|dir -> 0000.
   - DUTY_VALUE steps 250/500/750/1000.
   - DONE pulses once; PULSE_CNT>=10; FAULT_CODE=00.
2. CMD_PULSES=0 -> DONE exactly 1 cycle after accept, BUSY stays 0, M_C stays 0000.
3. No tacho edges after RAMP entry -> FAULT_CODE=01 after 200 cycles; M_C=0000; CMD_READY=0 until FAULT_CLR, then CMD_READY=1 with no DONE.
4. DIAG held low 2 cycles (after sync) during RUN -> FAULT_CODE=10, DUTY_VALUE=0. A 1-cycle DIAG glitch -> no fault.
5. ABORT asserted in RAMP on the same cycle as the target edge -> BRAKE, FAULT_CODE=11, DONE after BRAKE_HOLD. RST asserted in RUN -> all outputs 0 next cycle.
6. With MOVE_SEQ_DECEL_EN, DECEL_PULSES=4, CMD_PULSES=10 -> DUTY_VALUE begins decreasing at PULSE_CNT=6, never below 250, then BRAKE at 10.
